// File: rtl/hdlc_destuff_sched.sv
// Round-robin frame scheduler that time-shares one HDLC byte destuffer between NUM_CH channels.
// Forwards the granted channel's sop/eop/data stream registered, truncating and timing out as needed.
module hdlc_destuff_sched #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned MAX_LEN  = 10,
  parameter int unsigned SOP_TO   = 8,
  parameter int unsigned DRAIN_TO = 16,
  parameter int unsigned GAP      = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_CH-1:0]         i_ch_req,
  input  logic [NUM_CH-1:0]         i_ch_sop,
  input  logic [NUM_CH-1:0]         i_ch_eop,
  input  logic [8*NUM_CH-1:0]       i_ch_data,
  output logic [NUM_CH-1:0]         o_ch_gnt,
  output logic                      o_sop_delin,
  output logic                      o_eop_delin,
  output logic [7:0]                o_data_delin,
  input  logic                      i_eop_des,
  output logic [$clog2(NUM_CH)-1:0] o_cur_ch,
  output logic                      o_busy,
  output logic                      o_len_err,
  output logic                      o_to_err
);

  localparam int unsigned CW = $clog2(NUM_CH);
  localparam logic [CW-1:0] LastCh    = CW'(NUM_CH - 1);
  localparam logic [7:0]    SopLast   = 8'(SOP_TO - 1);
  localparam logic [7:0]    DrainLast = 8'(DRAIN_TO - 1);
  localparam logic [7:0]    LenLast   = 8'(MAX_LEN - 1);
  localparam logic [7:0]    GapLast   = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

  typedef enum logic [2:0] {StIdle, StWaitSop, StXfer, StDrain, StGap} state_e;

  state_e            r_state;
  logic [CW-1:0]     r_rr;
  logic [CW-1:0]     r_cur_ch;
  logic [NUM_CH-1:0] r_gnt;
  logic [7:0]        r_cnt;
  logic              r_sop;
  logic              r_eop;
  logic [7:0]        r_data;
  logic              r_len_err;
  logic              r_to_err;

  logic              w_found;
  logic [CW-1:0]     w_pick;
  logic              w_sop;
  logic              w_eop;
  logic [7:0]        w_data;

  function automatic logic [7:0] sat_inc(logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      idx = (int'(r_rr) + i) % int'(NUM_CH);
      if (!w_found && i_ch_req[idx]) begin
        w_found = 1'b1;
        w_pick  = CW'(idx);
      end
    end
  end

  assign w_sop  = i_ch_sop[r_cur_ch];
  assign w_eop  = i_ch_eop[r_cur_ch];
  assign w_data = i_ch_data[{r_cur_ch, 3'b000} +: 8];

  // r_cnt doubles as byte count in StXfer and as the cycle timer in every other state.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= StIdle;
      r_rr      <= '0;
      r_cur_ch  <= '0;
      r_gnt     <= '0;
      r_cnt     <= '0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_data    <= '0;
      r_len_err <= 1'b0;
      r_to_err  <= 1'b0;
    end else begin
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_data    <= '0;
      r_len_err <= 1'b0;
      r_to_err  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_found) begin
            r_gnt    <= NUM_CH'(1) << w_pick;
            r_cur_ch <= w_pick;
            r_cnt    <= '0;
            r_state  <= StWaitSop;
          end
        end
        StWaitSop: begin
          if (w_sop) begin
            r_sop  <= 1'b1;
            r_data <= w_data;
            if (w_eop) begin
              r_eop   <= 1'b1;
              r_gnt   <= '0;
              r_cnt   <= '0;
              r_state <= StDrain;
            end else begin
              r_cnt   <= 8'd1;
              r_state <= StXfer;
            end
          end else if (r_cnt >= SopLast) begin
            r_to_err <= 1'b1;
            r_gnt    <= '0;
            r_cnt    <= '0;
            r_state  <= StGap;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        StXfer: begin
          r_data <= w_data;
          if (w_eop || r_cnt >= LenLast) begin
            r_eop     <= 1'b1;
            r_len_err <= ~w_eop;
            r_gnt     <= '0;
            r_cnt     <= '0;
            r_state   <= StDrain;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        StDrain: begin
          if (i_eop_des) begin
            r_cnt   <= '0;
            r_state <= StGap;
          end else if (r_cnt >= DrainLast) begin
            r_to_err <= 1'b1;
            r_cnt    <= '0;
            r_state  <= StGap;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        StGap: begin
          if (r_cnt >= GapLast) begin
            r_rr    <= (r_cur_ch == LastCh) ? '0 : r_cur_ch + 1'b1;
            r_cnt   <= '0;
            r_state <= StIdle;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        default: begin
          r_gnt   <= '0;
          r_cnt   <= '0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_ch_gnt     = r_gnt;
  assign o_sop_delin  = r_sop;
  assign o_eop_delin  = r_eop;
  assign o_data_delin = r_data;
  assign o_cur_ch     = r_cur_ch;
  assign o_busy       = (r_state != StIdle);
  assign o_len_err    = r_len_err;
  assign o_to_err     = r_to_err;

endmodule

// File: tb/tb_hdlc_destuff_sched.sv
// Randomized bench for hdlc_destuff_sched: channel drivers and a destuffer stub react to grants,
// while a frame-level model predicts grant order, forwarded frames and error pulses.
module tb_hdlc_destuff_sched;

  localparam int NCH  = 4;
  localparam int MAXL = 10;
  localparam int SOPT = 8;
  localparam int DRT  = 16;

  typedef struct packed {
    logic [3:0]   ch;
    logic [4:0]   len;
    logic [127:0] b;
  } frm_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   ch_req, ch_sop, ch_eop, ch_gnt;
  logic [8*NCH-1:0] ch_data;
  logic             sop_delin, eop_delin, eop_des, busy, len_err, to_err;
  logic [7:0]       data_delin;
  logic [1:0]       cur_ch;

  always #5 clk = ~clk;

  hdlc_destuff_sched #(
    .NUM_CH(NCH), .MAX_LEN(MAXL), .SOP_TO(SOPT), .DRAIN_TO(DRT), .GAP(1)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_ch_req(ch_req), .i_ch_sop(ch_sop), .i_ch_eop(ch_eop),
    .i_ch_data(ch_data), .o_ch_gnt(ch_gnt), .o_sop_delin(sop_delin), .o_eop_delin(eop_delin),
    .o_data_delin(data_delin), .i_eop_des(eop_des), .o_cur_ch(cur_ch), .o_busy(busy),
    .o_len_err(len_err), .o_to_err(to_err)
  );

  int total = 0;
  int bad   = 0;

  // Per-channel frame descriptors: d_pre >= SOPT means the channel never sends sop,
  // d_drain < 0 means the destuffer never answers with eop_des.
  int         d_len   [NCH];
  int         d_pre   [NCH];
  int         d_drain [NCH];
  logic [7:0] d_byte  [NCH][16];
  logic       d_sin   [NCH][16];

  int             pos [NCH];
  logic [NCH-1:0] pend;
  logic [NCH-1:0] prev_gnt;
  int             exp_order[$];
  frm_t           exp_frm[$];
  logic [7:0]     obs[$];
  logic           in_frm;
  int             des_cnt;
  int             model_rr;
  int             exp_len = 0, exp_to = 0, n_len = 0, n_to = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: sample outputs at negedge, then drive destuffer stub and channels.
  task automatic tick();
    int   g, e, mism, idx;
    frm_t f;
    @(negedge clk);
    check_eq("gnt_onehot", int'($onehot0(ch_gnt)), 1);
    if (prev_gnt == '0 && ch_gnt != '0) begin
      g = 0;
      for (int k = 0; k < NCH; k++) if (ch_gnt[k]) g = k;
      if (exp_order.size() == 0) check_eq("gnt_unexp", g, NCH);
      else begin
        e = exp_order.pop_front();
        check_eq("gnt_ch", g, e);
        check_eq("cur_ch", int'(cur_ch), e);
      end
    end
    if (len_err) n_len++;
    if (to_err) n_to++;
    if (sop_delin) begin
      in_frm = 1'b1;
      obs.delete();
    end
    if (in_frm) begin
      obs.push_back(data_delin);
      if (eop_delin) begin
        in_frm = 1'b0;
        if (exp_frm.size() == 0) check_eq("frm_unexp", obs.size(), 0);
        else begin
          f = exp_frm.pop_front();
          check_eq("frm_len", obs.size(), int'(f.len));
          mism = 0;
          for (int i = 0; i < obs.size() && i < 16; i++)
            if (obs[i] != f.b[8*i +: 8]) mism++;
          check_eq("frm_data", mism, 0);
          des_cnt = d_drain[f.ch];
        end
      end
    end else begin
      check_eq("idle_out", int'({eop_delin, data_delin}), 0);
    end
    eop_des = 1'b0;
    if (des_cnt == 0) begin
      eop_des = 1'b1;
      des_cnt = -1;
    end else if (des_cnt > 0) begin
      des_cnt--;
    end
    for (int k = 0; k < NCH; k++) begin
      ch_sop[k] = 1'b0;
      ch_eop[k] = 1'b0;
      ch_data[8*k +: 8] = 8'h00;
      if (ch_gnt[k]) begin
        pend[k] = 1'b0;
        if (pos[k] < d_pre[k]) begin
          ch_eop[k] = 1'($urandom % 2);
          ch_data[8*k +: 8] = 8'($urandom);
        end else begin
          idx = pos[k] - d_pre[k];
          if (idx < d_len[k]) begin
            ch_data[8*k +: 8] = d_byte[k][idx];
            ch_sop[k] = (idx == 0) | d_sin[k][idx];
            ch_eop[k] = (idx == d_len[k] - 1);
          end
        end
        pos[k]++;
      end else begin
        pos[k] = 0;
      end
    end
    ch_req   = pend;
    prev_gnt = ch_gnt;
  endtask

  task automatic set_desc(input int k, input int len, input int pre, input int drain);
    d_len[k]   = len;
    d_pre[k]   = pre;
    d_drain[k] = drain;
    for (int i = 0; i < 16; i++) begin
      d_byte[k][i] = 8'($urandom);
      d_sin[k][i]  = (i != 0) && ($urandom % 4 == 0);
    end
  endtask

  // Predict the round: each requester is served once, round-robin from the model pointer.
  task automatic run_round(input logic [NCH-1:0] mask);
    logic [NCH-1:0] m;
    int   k, cyc;
    frm_t f;
    m = mask;
    while (m != '0) begin
      k = 0;
      for (int i = NCH - 1; i >= 0; i--) if (m[(model_rr + i) % NCH]) k = (model_rr + i) % NCH;
      exp_order.push_back(k);
      if (d_pre[k] >= SOPT) exp_to++;
      else begin
        f.ch  = 4'(k);
        f.len = 5'((d_len[k] > MAXL) ? MAXL : d_len[k]);
        f.b   = '0;
        for (int i = 0; i < 16; i++) f.b[8*i +: 8] = d_byte[k][i];
        exp_frm.push_back(f);
        if (d_len[k] > MAXL) exp_len++;
        if (d_drain[k] < 0) exp_to++;
      end
      model_rr = (k + 1) % NCH;
      m[k] = 1'b0;
    end
    pend = pend | mask;
    cyc = 0;
    while ((pend != '0 || busy || in_frm) && cyc < 3000) begin
      tick();
      cyc++;
    end
    check_eq("round_done", int'(cyc < 3000), 1);
    repeat (3) tick();
    check_eq("len_err_cnt", n_len, exp_len);
    check_eq("to_err_cnt", n_to, exp_to);
    check_eq("order_left", exp_order.size(), 0);
    check_eq("frm_left", exp_frm.size(), 0);
    exp_order.delete();
    exp_frm.delete();
  endtask

  task automatic check_reset_outs();
    check_eq("rst_gnt", int'(ch_gnt), 0);
    check_eq("rst_sop_eop", int'({sop_delin, eop_delin}), 0);
    check_eq("rst_data", int'(data_delin), 0);
    check_eq("rst_cur_ch", int'(cur_ch), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_errs", int'({len_err, to_err}), 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b0;
    ch_req = '0; ch_sop = '0; ch_eop = '0; ch_data = '0; eop_des = 1'b0;
    pend = '0; prev_gnt = '0; in_frm = 1'b0; des_cnt = -1; model_rr = 0;
    for (int k = 0; k < NCH; k++) begin
      pos[k] = 0;
      set_desc(k, 3, 0, 4);
    end
    repeat (3) tick();
    check_reset_outs();
    rst = 1'b1;
    tick();

    // Single channel 2: 7E 7D 5E 01 7E.
    set_desc(2, 5, 0, 3);
    d_byte[2][0] = 8'h7E; d_byte[2][1] = 8'h7D; d_byte[2][2] = 8'h5E;
    d_byte[2][3] = 8'h01; d_byte[2][4] = 8'h7E;
    run_round(4'b0100);

    // SOP timeout on channel 1, then channel 2 gets the next grant.
    set_desc(1, 3, 100, 4);
    set_desc(2, 4, 1, 2);
    run_round(4'b0110);

    // One-byte frame 0x55 with no eop_des: drain timeout.
    set_desc(0, 1, 0, -1);
    d_byte[0][0] = 8'h55;
    run_round(4'b0001);

    // Oversize 14-byte frame truncated at MAX_LEN.
    set_desc(3, 14, 2, 5);
    run_round(4'b1000);

    // Move the pointer away from 0, then reset in the middle of a frame.
    set_desc(1, 2, 0, 1);
    run_round(4'b0010);
    set_desc(1, 14, 0, 3);
    exp_order.push_back(1);
    pend[1] = 1'b1;
    cyc = 0;
    while (!(in_frm && obs.size() == 3) && cyc < 100) begin
      tick();
      cyc++;
    end
    check_eq("mid_frame_reached", int'(cyc < 100), 1);
    rst = 1'b0;
    tick();
    check_reset_outs();
    in_frm = 1'b0;
    obs.delete();
    des_cnt = -1;
    exp_order.delete();
    model_rr = 0;
    rst = 1'b1;
    tick();

    // Round-robin from channel 0 with all four requesting.
    for (int k = 0; k < NCH; k++) set_desc(k, 3, 0, 4);
    run_round(4'b1111);
    run_round(4'b0001);

    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < NCH; k++)
        set_desc(k, int'($urandom_range(1, 14)),
                 ($urandom % 10 == 0) ? SOPT + 5 : int'($urandom % SOPT),
                 ($urandom % 8 == 0) ? -1 : int'($urandom % DRT));
      run_round((4'($urandom) == 4'b0000) ? 4'b1111 : 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
